// File: rtl/acc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : acc_pkg
// Description : Shared types for the accelerator response reorder stage.
//               Holds the reorder-entry state encoding and the helper that
//               sizes tag indices and pointers from the entry count.
// Revision    : 1.0  initial release
// ============================================================================
package acc_pkg;

    // Lifecycle of one reorder entry: allocated on issue, filled on response,
    // released when the core takes the response.
    typedef enum logic [1:0] {
        ENTRY_FREE   = 2'd0,
        ENTRY_ISSUED = 2'd1,
        ENTRY_DONE   = 2'd2
    } entry_state_e;

    // Width of a tag index / ring pointer for a given entry count.
    // A single entry still needs a one-bit signal to be legal RTL.
    function automatic int idx_width(input int num_tags);
        return (num_tags > 1) ? $clog2(num_tags) : 1;
    endfunction

endpackage : acc_pkg
`default_nettype wire

// File: rtl/acc_rob_entry.sv
`default_nettype none
// ============================================================================
// Module      : acc_rob_entry
// Description : One reorder-buffer entry: state register plus the captured
//               response data and error flag.
//   clk_i, rst_n          : clock, asynchronous active-high reset
//   issue_i               : request handshake targets this entry
//   capture_i             : legal response handshake targets this entry
//   retire_i              : core response handshake targets this entry
//   data_i, error_i       : response payload to store on capture
//   state_o, data_o,
//   error_o               : current entry contents
// Revision    : 1.0  initial release
// ============================================================================
module acc_rob_entry
    import acc_pkg::*;
#(
    parameter int DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_n,
    input  logic                 issue_i,
    input  logic                 capture_i,
    input  logic                 retire_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 error_i,
    output entry_state_e         state_o,
    output logic [DataWidth-1:0] data_o,
    output logic                 error_o
);

    typedef struct packed {
        entry_state_e         state;
        logic [DataWidth-1:0] data;
        logic                 error;
    } rob_entry_t;

    rob_entry_t   r_entry;
    entry_state_e w_next_state;
    logic         w_store;

    always_comb begin
        w_next_state = r_entry.state;
        w_store      = 1'b0;
        case (r_entry.state)
            ENTRY_FREE: begin
                if (issue_i) begin
                    w_next_state = ENTRY_ISSUED;
                end
            end
            ENTRY_ISSUED: begin
                if (capture_i) begin
                    w_next_state = ENTRY_DONE;
                    w_store      = 1'b1;
                end
            end
            ENTRY_DONE: begin
                if (retire_i) begin
                    w_next_state = ENTRY_FREE;
                end
            end
            default: begin
                w_next_state = ENTRY_FREE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_n) begin
        if (rst_n) begin
            r_entry <= '{state: ENTRY_FREE, data: '0, error: 1'b0};
        end else begin
            r_entry.state <= w_next_state;
            if (w_store) begin
                r_entry.data  <= data_i;
                r_entry.error <= error_i;
            end
        end
    end

    assign state_o = r_entry.state;
    assign data_o  = r_entry.data;
    assign error_o = r_entry.error;

endmodule : acc_rob_entry
`default_nettype wire

// File: rtl/acc_rsp_reorder.sv
`default_nettype none
// ============================================================================
// Module      : acc_rsp_reorder
// Description : Master-side reorder stage. Tags each offloaded core request
//               with an in-order ID, captures out-of-order responses from the
//               interconnect, and hands them back to the core in issue order.
//   core_q_*        : core request (fall-through to acc_q_*)
//   core_p_*        : in-order response to the core
//   acc_q_*         : request to interconnect, acc_q_id_o = allocated tag
//   acc_p_*         : response from interconnect, always accepted
//   outstanding_o   : number of entries not FREE
//   id_err_o        : one-cycle pulse after a response with an illegal ID
// Revision    : 1.0  initial release
// ============================================================================
module acc_rsp_reorder
    import acc_pkg::*;
#(
    parameter int DataWidth    = 32,
    parameter int AccAddrWidth = 3,
    parameter int IdWidth      = 5,
    parameter int NumTags      = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_n,
    input  logic                       core_q_valid_i,
    output logic                       core_q_ready_o,
    input  logic [AccAddrWidth-1:0]    core_q_addr_i,
    input  logic [DataWidth-1:0]       core_q_data_i,
    output logic                       core_p_valid_o,
    input  logic                       core_p_ready_i,
    output logic [DataWidth-1:0]       core_p_data_o,
    output logic                       core_p_error_o,
    output logic                       acc_q_valid_o,
    input  logic                       acc_q_ready_i,
    output logic [AccAddrWidth-1:0]    acc_q_addr_o,
    output logic [DataWidth-1:0]       acc_q_data_o,
    output logic [IdWidth-1:0]         acc_q_id_o,
    input  logic                       acc_p_valid_i,
    output logic                       acc_p_ready_o,
    input  logic [DataWidth-1:0]       acc_p_data_i,
    input  logic                       acc_p_error_i,
    input  logic [IdWidth-1:0]         acc_p_id_i,
    output logic [$clog2(NumTags+1)-1:0] outstanding_o,
    output logic                       id_err_o
);

    localparam int TAG_W = idx_width(NumTags);
    localparam int CNT_W = $clog2(NumTags + 1);

    logic [TAG_W-1:0]     r_wr_ptr;
    logic [TAG_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic                 r_id_err;

    entry_state_e         w_state [NumTags];
    logic [DataWidth-1:0] w_data  [NumTags];
    logic                 w_error [NumTags];

    logic                 w_full;
    logic                 w_issue;
    logic                 w_retire;
    logic                 w_upper_zero;
    logic                 w_id_legal;
    logic                 w_capture;
    logic [TAG_W-1:0]     w_rsp_idx;

    // Full comes from the registered count only, so a retire frees a slot
    // for the following cycle and never combinationally unblocks issue.
    assign w_full         = (r_count == CNT_W'(NumTags));
    assign acc_q_valid_o  = core_q_valid_i & ~w_full;
    assign core_q_ready_o = acc_q_ready_i & ~w_full;
    assign acc_q_addr_o   = core_q_addr_i;
    assign acc_q_data_o   = core_q_data_i;
    assign acc_q_id_o     = IdWidth'(r_wr_ptr);
    assign w_issue        = core_q_valid_i & acc_q_ready_i & ~w_full;

    // Every issued request owns an entry, so responses are never stalled.
    assign acc_p_ready_o  = 1'b1;

    assign core_p_valid_o = (w_state[r_rd_ptr] == ENTRY_DONE);
    assign core_p_data_o  = w_data[r_rd_ptr];
    assign core_p_error_o = w_error[r_rd_ptr];
    assign w_retire       = core_p_valid_o & core_p_ready_i;

    // ID bits above the tag index must be zero to address a real entry.
    generate
        if (IdWidth > TAG_W) begin : g_id_upper
            assign w_upper_zero = ~|acc_p_id_i[IdWidth-1:TAG_W];
        end else begin : g_id_no_upper
            assign w_upper_zero = 1'b1;
        end
    endgenerate

    assign w_rsp_idx  = acc_p_id_i[TAG_W-1:0];
    assign w_id_legal = w_upper_zero & (w_state[w_rsp_idx] == ENTRY_ISSUED);
    assign w_capture  = acc_p_valid_i & w_id_legal;

    generate
        for (genvar g = 0; g < NumTags; g++) begin : g_entry
            acc_rob_entry #(
                .DataWidth (DataWidth)
            ) u_entry (
                .clk_i     (clk_i),
                .rst_n     (rst_n),
                .issue_i   (w_issue   & (r_wr_ptr  == TAG_W'(g))),
                .capture_i (w_capture & (w_rsp_idx == TAG_W'(g))),
                .retire_i  (w_retire  & (r_rd_ptr  == TAG_W'(g))),
                .data_i    (acc_p_data_i),
                .error_i   (acc_p_error_i),
                .state_o   (w_state[g]),
                .data_o    (w_data[g]),
                .error_o   (w_error[g])
            );
        end
    endgenerate

    // NumTags is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk_i or posedge rst_n) begin
        if (rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_id_err <= 1'b0;
        end else begin
            r_id_err <= acc_p_valid_i & ~w_id_legal;
            if (w_issue) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_retire) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_issue, w_retire})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign outstanding_o = r_count;
    assign id_err_o      = r_id_err;

endmodule : acc_rsp_reorder
`default_nettype wire

// File: tb/tb_acc_rsp_reorder.sv
`default_nettype none
// ============================================================================
// Module      : tb_acc_rsp_reorder
// Description : Self-checking bench for acc_rsp_reorder. A queue of
//               outstanding requests in issue order serves as the reference.
// Revision    : 1.0  initial release
// ============================================================================
module tb_acc_rsp_reorder;

    localparam int DW = 32;
    localparam int AW = 3;
    localparam int IW = 5;
    localparam int NT = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          core_q_valid_i;
    logic          core_q_ready_o;
    logic [AW-1:0] core_q_addr_i;
    logic [DW-1:0] core_q_data_i;
    logic          core_p_valid_o;
    logic          core_p_ready_i;
    logic [DW-1:0] core_p_data_o;
    logic          core_p_error_o;
    logic          acc_q_valid_o;
    logic          acc_q_ready_i;
    logic [AW-1:0] acc_q_addr_o;
    logic [DW-1:0] acc_q_data_o;
    logic [IW-1:0] acc_q_id_o;
    logic          acc_p_valid_i;
    logic          acc_p_ready_o;
    logic [DW-1:0] acc_p_data_i;
    logic          acc_p_error_i;
    logic [IW-1:0] acc_p_id_i;
    logic [CW-1:0] outstanding_o;
    logic          id_err_o;

    always #5 clk = ~clk;

    acc_rsp_reorder #(
        .DataWidth    (DW),
        .AccAddrWidth (AW),
        .IdWidth      (IW),
        .NumTags      (NT)
    ) dut (
        .clk_i          (clk),
        .rst_n          (rst_n),
        .core_q_valid_i (core_q_valid_i),
        .core_q_ready_o (core_q_ready_o),
        .core_q_addr_i  (core_q_addr_i),
        .core_q_data_i  (core_q_data_i),
        .core_p_valid_o (core_p_valid_o),
        .core_p_ready_i (core_p_ready_i),
        .core_p_data_o  (core_p_data_o),
        .core_p_error_o (core_p_error_o),
        .acc_q_valid_o  (acc_q_valid_o),
        .acc_q_ready_i  (acc_q_ready_i),
        .acc_q_addr_o   (acc_q_addr_o),
        .acc_q_data_o   (acc_q_data_o),
        .acc_q_id_o     (acc_q_id_o),
        .acc_p_valid_i  (acc_p_valid_i),
        .acc_p_ready_o  (acc_p_ready_o),
        .acc_p_data_i   (acc_p_data_i),
        .acc_p_error_i  (acc_p_error_i),
        .acc_p_id_i     (acc_p_id_i),
        .outstanding_o  (outstanding_o),
        .id_err_o       (id_err_o)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- reference model: outstanding requests in issue order
    typedef struct {
        int          tag;
        bit          done;
        logic [31:0] data;
        bit          err;
    } ment_t;

    ment_t mq[$];
    int    m_next_tag = 0;
    bit    m_iderr    = 1'b0;

    function automatic bit m_full();
        return mq.size() == NT;
    endfunction

    function automatic bit m_pvalid();
        return (mq.size() > 0) && mq[0].done;
    endfunction

    task automatic m_reset();
        mq.delete();
        m_next_tag = 0;
        m_iderr    = 1'b0;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        check("acc_q_valid", acc_q_valid_o, core_q_valid_i && !m_full());
        check("core_q_ready", core_q_ready_o, acc_q_ready_i && !m_full());
        check("acc_q_id", acc_q_id_o, m_next_tag);
        check("acc_q_addr", acc_q_addr_o, core_q_addr_i);
        check("acc_q_data", acc_q_data_o, core_q_data_i);
        check("acc_p_ready", acc_p_ready_o, 1);
        check("core_p_valid", core_p_valid_o, m_pvalid());
        if (m_pvalid()) begin
            check("core_p_data", core_p_data_o, mq[0].data);
            check("core_p_error", core_p_error_o, mq[0].err);
        end
        check("outstanding", outstanding_o, mq.size());
        check("id_err", id_err_o, m_iderr);
    endtask

    task automatic model_update();
        bit retire;
        bit issue;
        int hit;
        if (rst_n) begin
            m_reset();
            return;
        end
        retire = m_pvalid() && core_p_ready_i;
        issue  = core_q_valid_i && acc_q_ready_i && !m_full();
        hit    = -1;
        if (acc_p_id_i < NT) begin
            foreach (mq[i]) begin
                if (mq[i].tag == int'(acc_p_id_i) && !mq[i].done) hit = i;
            end
        end
        if (acc_p_valid_i && hit >= 0) begin
            mq[hit].done = 1'b1;
            mq[hit].data = acc_p_data_i;
            mq[hit].err  = acc_p_error_i;
        end
        m_iderr = acc_p_valid_i && (hit < 0);
        if (retire) void'(mq.pop_front());
        if (issue) begin
            mq.push_back('{m_next_tag, 1'b0, 32'h0, 1'b0});
            m_next_tag = (m_next_tag + 1) % NT;
        end
    endtask

    // Caller drives inputs just after a rising edge; outputs are sampled
    // a few ns later, well before the next edge.
    task automatic settle();
        #3;
    endtask

    task automatic finish_cycle();
        model_check();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        settle();
        finish_cycle();
    endtask

    task automatic idle_inputs();
        core_q_valid_i = 0; acc_q_ready_i = 0; core_q_addr_i = '0; core_q_data_i = '0;
        acc_p_valid_i  = 0; acc_p_id_i    = '0; acc_p_data_i  = '0; acc_p_error_i = 0;
        core_p_ready_i = 0;
    endtask

    task automatic pick_undone(output bit found, output int tag);
        int cand[$];
        found = 1'b0;
        tag   = 0;
        foreach (mq[i]) if (!mq[i].done) cand.push_back(mq[i].tag);
        if (cand.size() > 0) begin
            found = 1'b1;
            tag   = cand[$urandom_range(cand.size() - 1, 0)];
        end
    endtask

    // ---------------- directed vectors with hand-derived expectations
    typedef struct {
        bit          qv;
        logic [2:0]  addr;
        logic [31:0] qdata;
        bit          pv;
        logic [4:0]  pid;
        logic [31:0] pdata;
        bit          perr;
        bit          cr;
        int          e_qid;
        bit          e_pv;
        logic [31:0] e_pdata;
        bit          e_perr;
        int          e_out;
        bit          e_iderr;
    } vec_t;

    vec_t vecs[18];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int tag;
        int guard;
        int late_tag;
        int cnt_before;

        //           qv addr   qdata    pv pid     pdata    perr cr  qid pv pdata    perr out iderr
        vecs[0]  = '{1, 3'd2, 32'h1234, 0, 5'd0,  32'h0,    0,   0,  0,  0, 32'h0,    0,   0,  0};
        vecs[1]  = '{0, 3'd0, 32'h0,    1, 5'd0,  32'hBEEF, 0,   0,  1,  0, 32'h0,    0,   1,  0};
        vecs[2]  = '{0, 3'd0, 32'h0,    0, 5'd0,  32'h0,    0,   0,  1,  1, 32'hBEEF, 0,   1,  0};
        vecs[3]  = '{0, 3'd0, 32'h0,    0, 5'd0,  32'h0,    0,   1,  1,  1, 32'hBEEF, 0,   1,  0};
        vecs[4]  = '{0, 3'd0, 32'h0,    0, 5'd0,  32'h0,    0,   0,  1,  0, 32'h0,    0,   0,  0};
        vecs[5]  = '{1, 3'd1, 32'h11,   0, 5'd0,  32'h0,    0,   0,  1,  0, 32'h0,    0,   0,  0};
        vecs[6]  = '{1, 3'd3, 32'h22,   0, 5'd0,  32'h0,    0,   0,  2,  0, 32'h0,    0,   1,  0};
        vecs[7]  = '{1, 3'd5, 32'h33,   0, 5'd0,  32'h0,    0,   0,  3,  0, 32'h0,    0,   2,  0};
        vecs[8]  = '{0, 3'd0, 32'h0,    1, 5'd3,  32'hA2,   1,   1,  4,  0, 32'h0,    0,   3,  0};
        vecs[9]  = '{0, 3'd0, 32'h0,    1, 5'd1,  32'hA0,   0,   1,  4,  0, 32'h0,    0,   3,  0};
        vecs[10] = '{0, 3'd0, 32'h0,    1, 5'd2,  32'hA1,   0,   1,  4,  1, 32'hA0,   0,   3,  0};
        vecs[11] = '{0, 3'd0, 32'h0,    0, 5'd0,  32'h0,    0,   1,  4,  1, 32'hA1,   0,   2,  0};
        vecs[12] = '{0, 3'd0, 32'h0,    0, 5'd0,  32'h0,    0,   1,  4,  1, 32'hA2,   1,   1,  0};
        vecs[13] = '{0, 3'd0, 32'h0,    0, 5'd0,  32'h0,    0,   0,  4,  0, 32'h0,    0,   0,  0};
        vecs[14] = '{0, 3'd0, 32'h0,    1, 5'h10, 32'hDEAD, 0,   0,  4,  0, 32'h0,    0,   0,  0};
        vecs[15] = '{0, 3'd0, 32'h0,    1, 5'd5,  32'hDEAD, 0,   0,  4,  0, 32'h0,    0,   0,  1};
        vecs[16] = '{0, 3'd0, 32'h0,    0, 5'd0,  32'h0,    0,   0,  4,  0, 32'h0,    0,   0,  1};
        vecs[17] = '{0, 3'd0, 32'h0,    0, 5'd0,  32'h0,    0,   0,  4,  0, 32'h0,    0,   0,  0};

        idle_inputs();
        rst_n = 1'b1;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;

        // ---- directed table: single request, out-of-order return, bad IDs
        for (int i = 0; i < 18; i++) begin
            idle_inputs();
            acc_q_ready_i  = 1'b1;
            core_q_valid_i = vecs[i].qv;
            core_q_addr_i  = vecs[i].addr;
            core_q_data_i  = vecs[i].qdata;
            acc_p_valid_i  = vecs[i].pv;
            acc_p_id_i     = vecs[i].pid;
            acc_p_data_i   = vecs[i].pdata;
            acc_p_error_i  = vecs[i].perr;
            core_p_ready_i = vecs[i].cr;
            settle();
            check($sformatf("vec%0d q_id", i), acc_q_id_o, vecs[i].e_qid);
            check($sformatf("vec%0d q_ready", i), core_q_ready_o, 1);
            check($sformatf("vec%0d p_valid", i), core_p_valid_o, vecs[i].e_pv);
            if (vecs[i].e_pv) begin
                check($sformatf("vec%0d p_data", i), core_p_data_o, vecs[i].e_pdata);
                check($sformatf("vec%0d p_error", i), core_p_error_o, vecs[i].e_perr);
            end
            check($sformatf("vec%0d outstanding", i), outstanding_o, vecs[i].e_out);
            check($sformatf("vec%0d id_err", i), id_err_o, vecs[i].e_iderr);
            finish_cycle();
        end

        // ---- reset mid-operation with three outstanding
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            core_q_valid_i = 1; acc_q_ready_i = 1; core_q_data_i = 32'h100 + i;
            tick();
        end
        late_tag = mq[1].tag;
        idle_inputs();
        core_q_valid_i = 1;
        rst_n = 1'b1;
        m_reset();
        settle();
        check("rst outstanding", outstanding_o, 0);
        check("rst p_valid", core_p_valid_o, 0);
        check("rst id_err", id_err_o, 0);
        check("rst q_valid follows", acc_q_valid_o, 1);
        finish_cycle();
        rst_n = 1'b0;
        idle_inputs();
        acc_p_valid_i = 1; acc_p_id_i = IW'(late_tag); acc_p_data_i = 32'hBAD;
        tick();
        idle_inputs();
        core_q_valid_i = 1; acc_q_ready_i = 1;
        settle();
        check("late rsp id_err", id_err_o, 1);
        check("post-rst first id", acc_q_id_o, 0);
        finish_cycle();

        // ---- full: fill the remaining 7 entries, then try a ninth
        for (int i = 0; i < NT - 1; i++) begin
            core_q_valid_i = 1; acc_q_ready_i = 1; core_q_data_i = $urandom;
            tick();
        end
        settle();
        check("full q_ready", core_q_ready_o, 0);
        check("full q_valid", acc_q_valid_o, 0);
        check("full outstanding", outstanding_o, NT);
        acc_p_valid_i = 1; acc_p_id_i = '0; acc_p_data_i = 32'h5A5A;
        finish_cycle();
        acc_p_valid_i = 0; core_p_ready_i = 1;
        settle();
        check("retire-cycle q_valid", acc_q_valid_o, 0);
        finish_cycle();
        core_p_ready_i = 0;
        settle();
        check("wrap q_valid", acc_q_valid_o, 1);
        check("wrap q_id", acc_q_id_o, 0);
        finish_cycle();

        // ---- drain everything
        idle_inputs();
        guard = 0;
        while (mq.size() > 0 && guard < 200) begin
            idle_inputs();
            core_p_ready_i = 1;
            pick_undone(found, tag);
            if (found) begin
                acc_p_valid_i = 1; acc_p_id_i = IW'(tag); acc_p_data_i = $urandom;
                acc_p_error_i = 1'($urandom);
            end
            tick();
            guard++;
        end
        check("drain completes", mq.size(), 0);

        // ---- backpressure: hold a DONE head for 10 cycles
        idle_inputs();
        core_q_valid_i = 1; acc_q_ready_i = 1;
        tag = m_next_tag;
        tick();
        idle_inputs();
        acc_p_valid_i = 1; acc_p_id_i = IW'(tag); acc_p_data_i = 32'hC0DE;
        tick();
        for (int i = 0; i < 10; i++) begin
            idle_inputs();
            if (i == 3) begin
                core_q_valid_i = 1; acc_q_ready_i = 1;
            end
            settle();
            check($sformatf("bp%0d p_valid", i), core_p_valid_o, 1);
            check($sformatf("bp%0d p_data", i), core_p_data_o, 32'hC0DE);
            finish_cycle();
        end
        idle_inputs();
        core_p_ready_i = 1; core_q_valid_i = 1; acc_q_ready_i = 1;
        settle();
        cnt_before = int'(outstanding_o);
        finish_cycle();
        idle_inputs();
        settle();
        check("release+issue outstanding", outstanding_o, cnt_before);
        finish_cycle();

        // ---- randomized traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            idle_inputs();
            core_q_valid_i = ($urandom_range(9, 0) < 6);
            acc_q_ready_i  = ($urandom_range(9, 0) < 7);
            core_q_addr_i  = AW'($urandom);
            core_q_data_i  = $urandom;
            core_p_ready_i = ($urandom_range(9, 0) < 7);
            if ($urandom_range(9, 0) < 6) begin
                pick_undone(found, tag);
                acc_p_valid_i = 1;
                acc_p_data_i  = $urandom;
                acc_p_error_i = 1'($urandom);
                if (found && $urandom_range(3, 0) != 0) acc_p_id_i = IW'(tag);
                else acc_p_id_i = IW'($urandom);
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_acc_rsp_reorder
`default_nettype wire
